sd_rsp_rx_ctrl: RTL and testbench
=================================

Name: sd_rsp_rx_ctrl

Overview:
Sequencer for the CMD-line response receive path of the SD host. It waits for the start bit after a command is issued and drives the shift enable of the serial-to-parallel response register for exactly 48 or 136 bits. It also checks the end bit and, optionally, CRC7, enforces the NCR timeout, and releases the parallel response to the register block. It sits between the command FSM, the CMD pad sampler and the 48/136-bit serial-to-parallel register.

Parameters:
TimeoutCycles, 64, max SD-clock strobes in WAIT_START before timeout (NCR).
CntWidth, 8, width of bit/timeout counter; must hold max(136, TimeoutCycles).

Ports:
clk_i  in  1  system clock.
rst_i  in  1  reset, synchronous, active-high (clears all state on clk_i edge).
sd_clk_en_i  in  1  one-cycle strobe marking the sampling point of the CMD line.
cmd_i  in  1  sampled CMD line (serial data, MSb first).
start_i  in  1  pulse from command FSM: end of command sent, begin listening.
rsp_type_i  in  2  sd_rsp_pkg::rsp_type_e, sampled with start_i.
abort_i  in  1  abandon reception, return to IDLE.
shift_in_en_o  out  1  shift enable to the serial-to-parallel register.
par_output_en_o  out  1  output unmask to the serial-to-parallel register.
busy_o  out  1  high in WAIT_START or RECEIVE.
done_o  out  1  one-cycle pulse when reception or timeout completes.
timeout_err_o  out  1  sticky until next start_i.
end_bit_err_o  out  1  sticky until next start_i.
crc_err_o  out  1  sticky until next start_i.

Behaviour:
- Reset: state IDLE. All outputs 0. Counters 0. Latched rsp_type = RSP_48.
- States: IDLE, WAIT_START, RECEIVE, DONE.
- IDLE: start_i=1 → WAIT_START next cycle. Latch rsp_type_i. Clear the error flags and par_output_en_o. Timeout counter = 0.
- WAIT_START, per strobe: cmd_i=0 → shift_in_en_o=1 in that cycle (start bit is captured), bit count=1, go to RECEIVE. cmd_i=1 → increment timeout count. When the count reaches TimeoutCycles, set timeout_err_o and go to DONE.
- RECEIVE: shift_in_en_o = sd_clk_en_i (combinational, same cycle). The bit counter increments per strobe. Length N is 48 for RSP_48 and RSP_48_NO_CRC, and 136 for RSP_136.
- On the N-th bit: if cmd_i≠1, set end_bit_err_o. Then go to DONE.
- DONE: lasts one cycle. done_o=1 and par_output_en_o is set. Go to IDLE. par_output_en_o stays high until the next start_i or reset.
- Latency: done_o asserts the cycle after the strobe carrying the last bit.
- No strobe means no progress; the state holds indefinitely.
- CRC window:
  - RSP_48 covers bits 1..40 (1-based arrival order). Bits 41..47 are compared MSb first against the running CRC7.
  - RSP_136 covers bits 9..128 (bits 1..8 are the start/tx/reserved header and are excluded). Bits 129..135 are compared.
  - RSP_48_NO_CRC performs no check.
  - Any mismatching bit sets crc_err_o.
- abort_i: highest priority in any non-IDLE state. Next state is IDLE, with no done_o, and shift_in_en_o forced 0 in that cycle. Error flags are kept.
- start_i while busy_o=1 is ignored.
- Simultaneous start_i and abort_i in IDLE: abort_i wins, stay IDLE.
- Reset mid-reception: IDLE on the next edge; the partial response is discarded and par_output_en_o=0.

Optional Feature:
SDHCI_RSP_CRC_CHECK_EN:
- Defined: the CRC7 sub-module is instantiated and crc_err_o behaves as above.
- Undefined: no CRC logic is present, crc_err_o is tied to 0, and all response types behave as RSP_48_NO_CRC for checking, though length is still per type.

Decomposition:
- sd_rsp_pkg holds:
  - rsp_type_e {RSP_48=0, RSP_48_NO_CRC=1, RSP_136=2}
  - the state enum
  - constants RspLenShort=48, RspLenLong=136, CrcLen=7, R2HeaderLen=8
- Sub-module sd_crc7: serial CRC7 (x^7+x^3+1) with clear, enable and data inputs, and a 7-bit output. It is shared later by the command transmitter.

Test Plan:
- Frame 0x400000000095, RSP_48, start_i then 48 strobes → 48 shift pulses; done_o one cycle after the last strobe; all errors 0; par_output_en_o=1.
- Frame 0x510000000055 with bit 0 forced to 0 → end_bit_err_o=1, crc_err_o=0, done_o pulses.
- Frame 0x510000000057 (CRC field flipped) → crc_err_o=1 (macro defined) or 0 (macro undefined); with RSP_48_NO_CRC → 0 in both builds.
- cmd_i held 1 for 64 strobes after start_i → timeout_err_o=1 and done_o on the 64th; zero shift pulses.
- RSP_136 frame: header 0x3F, 120 bits of 0, then correct CRC and end bit → 136 shift pulses, no errors. Gaps of 3 idle cycles between strobes produce no extra shifts.
- abort_i at bit 20; then start_i during the abort cycle; then reset mid-frame → IDLE with no done_o; the second start ignored; after reset, outputs 0 and busy_o=0.

Source files
------------

// File: rtl/sd_rsp_pkg.sv
// Shared types and constants for the SD host CMD-line response receive path.
package sd_rsp_pkg;

    typedef enum logic [1:0] {
        RSP_48        = 2'd0,
        RSP_48_NO_CRC = 2'd1,
        RSP_136       = 2'd2
    } rsp_type_e;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_START = 2'd1,
        ST_RECEIVE    = 2'd2,
        ST_DONE       = 2'd3
    } rsp_state_e;

    localparam int RspLenShort = 48;
    localparam int RspLenLong  = 136;
    localparam int CrcLen      = 7;
    localparam int R2HeaderLen = 8;

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), MSb-first data. Shared by the command transmitter.
module sd_crc7 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       data_i,
    output logic [6:0] crc_o
);

    logic [6:0] crc_q;
    logic       fb;

    assign fb    = data_i ^ crc_q[6];
    assign crc_o = crc_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            crc_q <= 7'd0;
        end else if (en_i) begin
            crc_q <= {crc_q[5:0], 1'b0} ^ ({7{fb}} & 7'h09);
        end
    end

endmodule

// File: rtl/sd_rsp_rx_ctrl.sv
// CMD-line response receive sequencer: start-bit hunt, NCR timeout, 48/136-bit shift
// control, end-bit check. CRC7 checking is built only with SDHCI_RSP_CRC_CHECK_EN.
module sd_rsp_rx_ctrl
    import sd_rsp_pkg::*;
#(
    parameter int TimeoutCycles = 64,
    parameter int CntWidth      = 8
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      sd_clk_en_i,
    input  logic      cmd_i,
    input  logic      start_i,
    input  rsp_type_e rsp_type_i,
    input  logic      abort_i,
    output logic      shift_in_en_o,
    output logic      par_output_en_o,
    output logic      busy_o,
    output logic      done_o,
    output logic      timeout_err_o,
    output logic      end_bit_err_o,
    output logic      crc_err_o
);

    rsp_state_e            state_q, state_d;
    rsp_type_e             type_q, type_d;
    logic [CntWidth-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CntWidth-1:0]   to_cnt_q, to_cnt_d;
    logic [CntWidth-1:0]   cur_bit;
    logic [CntWidth-1:0]   rsp_len;
    logic                  to_err_q, to_err_d;
    logic                  eb_err_q, eb_err_d;
    logic                  crc_err_q, crc_err_d;
    logic                  par_en_q, par_en_d;
    logic                  rx_bit;
    logic                  crc_mis;

    // A bit is captured on every strobe in RECEIVE, and on the start bit in WAIT_START.
    assign rx_bit = sd_clk_en_i && !abort_i &&
                    ((state_q == ST_RECEIVE) || ((state_q == ST_WAIT_START) && !cmd_i));
    assign cur_bit = bit_cnt_q + CntWidth'(1);
    assign rsp_len = (type_q == RSP_136) ? CntWidth'(RspLenLong) : CntWidth'(RspLenShort);

    always_comb begin
        state_d   = state_q;
        type_d    = type_q;
        bit_cnt_d = bit_cnt_q;
        to_cnt_d  = to_cnt_q;
        to_err_d  = to_err_q;
        eb_err_d  = eb_err_q;
        crc_err_d = crc_err_q;
        par_en_d  = par_en_q;
        done_o    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i && !abort_i) begin
                    state_d   = ST_WAIT_START;
                    type_d    = rsp_type_i;
                    bit_cnt_d = '0;
                    to_cnt_d  = '0;
                    to_err_d  = 1'b0;
                    eb_err_d  = 1'b0;
                    crc_err_d = 1'b0;
                    par_en_d  = 1'b0;
                end
            end
            ST_WAIT_START: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (sd_clk_en_i) begin
                    if (!cmd_i) begin
                        bit_cnt_d = CntWidth'(1);
                        state_d   = ST_RECEIVE;
                    end else begin
                        to_cnt_d = to_cnt_q + CntWidth'(1);
                        if (to_cnt_d == CntWidth'(TimeoutCycles)) begin
                            to_err_d = 1'b1;
                            par_en_d = 1'b1;
                            state_d  = ST_DONE;
                        end
                    end
                end
            end
            ST_RECEIVE: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (sd_clk_en_i) begin
                    bit_cnt_d = cur_bit;
                    if (cur_bit == rsp_len) begin
                        if (!cmd_i) begin
                            eb_err_d = 1'b1;
                        end
                        par_en_d = 1'b1;
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done_o  = !abort_i;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef SDHCI_RSP_CRC_CHECK_EN
    logic [6:0]          crc_val;
    logic                crc_clr;
    logic                crc_en;
    logic                check_en;
    logic                in_data;
    logic                in_cmp;
    logic [CntWidth-1:0] data_first;
    logic [CntWidth-1:0] cmp_first;
    logic [CntWidth-1:0] cmp_off;
    logic [2:0]          crc_idx;

    // The R2 header (start, tx, reserved) is outside the CRC coverage.
    assign check_en   = (type_q == RSP_48) || (type_q == RSP_136);
    assign data_first = (type_q == RSP_136) ? CntWidth'(R2HeaderLen + 1) : CntWidth'(1);
    assign cmp_first  = rsp_len - CntWidth'(CrcLen);
    assign in_data    = (cur_bit >= data_first) && (cur_bit < cmp_first);
    assign in_cmp     = (cur_bit >= cmp_first) && (cur_bit < rsp_len);
    assign cmp_off    = cur_bit - cmp_first;
    assign crc_idx    = 3'(CrcLen - 1) - cmp_off[2:0];
    assign crc_clr    = (state_q == ST_IDLE) && start_i && !abort_i;
    assign crc_en     = rx_bit && check_en && in_data;
    assign crc_mis    = rx_bit && check_en && in_cmp && (cmd_i != crc_val[crc_idx]);

    sd_crc7 u_crc7 (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (crc_clr),
        .en_i   (crc_en),
        .data_i (cmd_i),
        .crc_o  (crc_val)
    );
`else
    assign crc_mis = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            type_q    <= RSP_48;
            bit_cnt_q <= '0;
            to_cnt_q  <= '0;
            to_err_q  <= 1'b0;
            eb_err_q  <= 1'b0;
            crc_err_q <= 1'b0;
            par_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            type_q    <= type_d;
            bit_cnt_q <= bit_cnt_d;
            to_cnt_q  <= to_cnt_d;
            to_err_q  <= to_err_d;
            eb_err_q  <= eb_err_d;
            crc_err_q <= crc_err_d | crc_mis;
            par_en_q  <= par_en_d;
        end
    end

    assign shift_in_en_o   = rx_bit;
    assign par_output_en_o = par_en_q;
    assign busy_o          = (state_q == ST_WAIT_START) || (state_q == ST_RECEIVE);
    assign timeout_err_o   = to_err_q;
    assign end_bit_err_o   = eb_err_q;
    assign crc_err_o       = crc_err_q;

endmodule

// File: tb/tb_sd_rsp_rx_ctrl.sv
// Directed bench for sd_rsp_rx_ctrl: vector table of whole frames plus abort/reset sequences.
module tb_sd_rsp_rx_ctrl;
    import sd_rsp_pkg::*;

`ifdef SDHCI_RSP_CRC_CHECK_EN
    localparam logic CrcOn = 1'b1;
`else
    localparam logic CrcOn = 1'b0;
`endif

    logic      clk = 1'b0;
    logic      rst_i = 1'b1;
    logic      sd_clk_en_i = 1'b0;
    logic      cmd_i = 1'b1;
    logic      start_i = 1'b0;
    rsp_type_e rsp_type_i = RSP_48;
    logic      abort_i = 1'b0;
    logic      shift_in_en_o, par_output_en_o, busy_o, done_o;
    logic      timeout_err_o, end_bit_err_o, crc_err_o;

    int checks = 0;
    int errors = 0;
    int shift_cnt = 0;
    int done_cnt = 0;
    logic last_shift, last_done;

    always #5 clk = ~clk;

    sd_rsp_rx_ctrl dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .sd_clk_en_i     (sd_clk_en_i),
        .cmd_i           (cmd_i),
        .start_i         (start_i),
        .rsp_type_i      (rsp_type_i),
        .abort_i         (abort_i),
        .shift_in_en_o   (shift_in_en_o),
        .par_output_en_o (par_output_en_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .timeout_err_o   (timeout_err_o),
        .end_bit_err_o   (end_bit_err_o),
        .crc_err_o       (crc_err_o)
    );

    typedef struct {
        string        name;
        logic [135:0] frame;
        rsp_type_e    typ;
        int           len;
        int           gap;
        int           exp_shift;
        logic         exp_to;
        logic         exp_eb;
        logic         exp_crc;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Inputs are applied just after a rising edge; outputs are sampled mid-cycle.
    task automatic tick();
        @(negedge clk);
        last_shift = shift_in_en_o;
        last_done  = done_o;
        shift_cnt += int'(shift_in_en_o);
        done_cnt  += int'(done_o);
        @(posedge clk);
        #1;
        start_i     = 1'b0;
        abort_i     = 1'b0;
        sd_clk_en_i = 1'b0;
        cmd_i       = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        shift_cnt = 0;
        done_cnt  = 0;
        start_i    = 1'b1;
        rsp_type_i = v.typ;
        tick();
        tick();
        check({v.name, " busy_after_start"}, int'(busy_o), 1);
        check({v.name, " par_cleared"}, int'(par_output_en_o), 0);
        for (int i = 0; i < v.len; i++) begin
            for (int g = 0; g < v.gap; g++) tick();
            sd_clk_en_i = 1'b1;
            cmd_i       = v.frame[v.len-1-i];
            tick();
        end
        tick();
        check({v.name, " done_latency"}, int'(last_done), 1);
        tick();
        tick();
        check({v.name, " done_count"}, done_cnt, 1);
        check({v.name, " shifts"}, shift_cnt, v.exp_shift);
        check({v.name, " timeout_err"}, int'(timeout_err_o), int'(v.exp_to));
        check({v.name, " end_bit_err"}, int'(end_bit_err_o), int'(v.exp_eb));
        check({v.name, " crc_err"}, int'(crc_err_o), int'(v.exp_crc));
        check({v.name, " par_en"}, int'(par_output_en_o), 1);
        check({v.name, " busy_idle"}, int'(busy_o), 0);
    endtask

    initial begin
        vecs[0] = '{"r48_ok",      136'h400000000095, RSP_48,        48, 0, 48,  1'b0, 1'b0, 1'b0};
        vecs[1] = '{"r48_endbit",  136'h510000000054, RSP_48,        48, 0, 48,  1'b0, 1'b1, 1'b0};
        vecs[2] = '{"r48_crcbad",  136'h510000000057, RSP_48,        48, 0, 48,  1'b0, 1'b0, CrcOn};
        vecs[3] = '{"r48nc_crc",   136'h510000000057, RSP_48_NO_CRC, 48, 0, 48,  1'b0, 1'b0, 1'b0};
        vecs[4] = '{"timeout",     136'hFFFFFFFFFFFFFFFF, RSP_48,    64, 0, 0,   1'b1, 1'b0, 1'b0};
        vecs[5] = '{"r136_ok_gap", {8'h3F, 120'h0, 8'h01}, RSP_136, 136, 3, 136, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{"r136_crcbad", {8'h3F, 120'h0, 8'h03}, RSP_136, 136, 1, 136, 1'b0, 1'b0, CrcOn};

        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;
        tick();
        check("reset busy", int'(busy_o), 0);
        check("reset done", int'(last_done), 0);
        check("reset shift", int'(last_shift), 0);
        check("reset par_en", int'(par_output_en_o), 0);
        check("reset errors", int'({timeout_err_o, end_bit_err_o, crc_err_o}), 0);

        for (int k = 0; k < 7; k++) run_vec(vecs[k]);

        // Abort on bit 20, with a start_i in the same cycle that must be ignored.
        shift_cnt = 0;
        done_cnt  = 0;
        start_i    = 1'b1;
        rsp_type_i = RSP_48;
        tick();
        for (int i = 0; i < 19; i++) begin
            sd_clk_en_i = 1'b1;
            cmd_i       = vecs[0].frame[47-i];
            tick();
        end
        check("abort pre shifts", shift_cnt, 19);
        sd_clk_en_i = 1'b1;
        cmd_i       = vecs[0].frame[28];
        abort_i     = 1'b1;
        start_i     = 1'b1;
        tick();
        check("abort shift_forced0", int'(last_shift), 0);
        tick();
        check("abort busy", int'(busy_o), 0);
        shift_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            sd_clk_en_i = 1'b1;
            cmd_i       = 1'b0;
            tick();
        end
        check("abort start_ignored shifts", shift_cnt, 0);
        check("abort no_done", done_cnt, 0);

        // start_i and abort_i together in IDLE: abort wins.
        start_i = 1'b1;
        abort_i = 1'b1;
        tick();
        tick();
        check("start_abort_idle busy", int'(busy_o), 0);

        // Reset in the middle of a frame.
        run_vec(vecs[0]);
        done_cnt   = 0;
        start_i    = 1'b1;
        rsp_type_i = RSP_48;
        tick();
        for (int i = 0; i < 30; i++) begin
            sd_clk_en_i = 1'b1;
            cmd_i       = vecs[0].frame[47-i];
            tick();
        end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        tick();
        check("midrst busy", int'(busy_o), 0);
        check("midrst par_en", int'(par_output_en_o), 0);
        check("midrst errors", int'({timeout_err_o, end_bit_err_o, crc_err_o}), 0);
        shift_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            sd_clk_en_i = 1'b1;
            cmd_i       = vecs[0].frame[17-i];
            tick();
        end
        check("midrst no_shift", shift_cnt, 0);
        check("midrst no_done", done_cnt, 0);

        run_vec(vecs[2]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
